// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: default sizes, the
// stage-A entry record and the register-0 address constant.
package operand_fetch_pkg;

    localparam int OPF_WORD_SIZE = 16;
    localparam int OPF_ADDR_SIZE = 3;
    localparam int OPF_TAG_SIZE  = 4;

    localparam logic [OPF_ADDR_SIZE-1:0] ZERO_ADDR = '0;

    // Instruction waiting in stage A for the register file read data.
    // bypN/byp_dataN hold the newest write seen to rsN since the read
    // was issued, which the registered read data cannot reflect.
    typedef struct packed {
        logic [OPF_ADDR_SIZE-1:0] rs1;
        logic [OPF_ADDR_SIZE-1:0] rs2;
        logic [OPF_TAG_SIZE-1:0]  tag;
        logic                     byp1;
        logic                     byp2;
        logic [OPF_WORD_SIZE-1:0] byp_data1;
        logic [OPF_WORD_SIZE-1:0] byp_data2;
    } a_entry_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, register-file, write-back tap and execute-side signals of the
// operand-fetch stage. The stage uses the slave modport; its environment
// (issue logic, register file, execute) uses the master modport.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int WORD_SIZE = OPF_WORD_SIZE,
    parameter int ADDR_SIZE = OPF_ADDR_SIZE,
    parameter int TAG_SIZE  = OPF_TAG_SIZE
);
    logic                 inValid;
    logic                 inReady;
    logic [ADDR_SIZE-1:0] inRs1;
    logic [ADDR_SIZE-1:0] inRs2;
    logic [TAG_SIZE-1:0]  inTag;
    logic [ADDR_SIZE-1:0] rfRdAddr1;
    logic [ADDR_SIZE-1:0] rfRdAddr2;
    logic [WORD_SIZE-1:0] rfRdData1;
    logic [WORD_SIZE-1:0] rfRdData2;
    logic                 wbEnable;
    logic [ADDR_SIZE-1:0] wbAddr;
    logic [WORD_SIZE-1:0] wbData;
    logic                 outValid;
    logic                 outReady;
    logic [WORD_SIZE-1:0] outOp1;
    logic [WORD_SIZE-1:0] outOp2;
    logic [TAG_SIZE-1:0]  outTag;

    modport slave (
        input  inValid, inRs1, inRs2, inTag,
        input  rfRdData1, rfRdData2,
        input  wbEnable, wbAddr, wbData,
        input  outReady,
        output inReady, rfRdAddr1, rfRdAddr2,
        output outValid, outOp1, outOp2, outTag
    );

    modport master (
        output inValid, inRs1, inRs2, inTag,
        output rfRdData1, rfRdData2,
        output wbEnable, wbAddr, wbData,
        output outReady,
        input  inReady, rfRdAddr1, rfRdAddr2,
        input  outValid, outOp1, outOp2, outTag
    );

endinterface

// File: rtl/operand_fetch_hazard_match.sv
// opf_hazard_match: compares the register file write port against one
// operand address and returns whether that write supersedes the operand.
// With OPF_ZERO_REG_EN defined, writes to register 0 never match.
module opf_hazard_match
    import operand_fetch_pkg::*;
#(
    parameter int WORD_SIZE = OPF_WORD_SIZE,
    parameter int ADDR_SIZE = OPF_ADDR_SIZE
) (
    input  logic                 wb_enable,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic [ADDR_SIZE-1:0] addr,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] data
);

`ifdef OPF_ZERO_REG_EN
    assign hit = wb_enable && (wb_addr == addr) && (addr != ZERO_ADDR);
`else
    assign hit = wb_enable && (wb_addr == addr);
`endif

    assign data = wb_data;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: two-stage operand fetch behind a registered 2R/1W
// register file. Stage A holds the issued instruction while its read data
// arrives, stage B is the output register towards execute. Writes that
// land after the read was issued are forwarded in A and snooped in B.
// Optional build macro OPF_ZERO_REG_EN: register 0 always reads as zero.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WORD_SIZE = OPF_WORD_SIZE,
    parameter int ADDR_SIZE = OPF_ADDR_SIZE,
    parameter int TAG_SIZE  = OPF_TAG_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    a_entry_t             a_reg;
    logic                 a_valid_reg;
    logic                 rst_done_reg;
    logic                 out_valid_reg;
    logic [WORD_SIZE-1:0] out_op_reg [2];
    logic [TAG_SIZE-1:0]  out_tag_reg;
    logic [ADDR_SIZE-1:0] b_rs_reg [2];

    logic                 a_adv;
    logic                 a_hold;
    logic                 in_ready;
    logic                 accept;
    logic [ADDR_SIZE-1:0] in_rs [2];
    logic [ADDR_SIZE-1:0] a_rs [2];
    logic                 a_byp [2];
    logic [WORD_SIZE-1:0] a_byp_data [2];
    logic [WORD_SIZE-1:0] rd_data [2];
    logic [ADDR_SIZE-1:0] rd_addr [2];
    logic [ADDR_SIZE-1:0] b_addr [2];
    logic                 hit_a [2];
    logic                 hit_b [2];
    logic [WORD_SIZE-1:0] data_a [2];
    logic [WORD_SIZE-1:0] data_b [2];
    logic [WORD_SIZE-1:0] a_op [2];
    logic [WORD_SIZE-1:0] b_op_next [2];

    assign a_adv    = a_valid_reg && (!out_valid_reg || bus.outReady);
    assign a_hold   = a_valid_reg && !a_adv;
    assign in_ready = rst_done_reg && !rst && (!a_valid_reg || a_adv);
    assign accept   = bus.inValid && in_ready;

    assign in_rs[0]      = bus.inRs1;
    assign in_rs[1]      = bus.inRs2;
    assign a_rs[0]       = a_reg.rs1;
    assign a_rs[1]       = a_reg.rs2;
    assign a_byp[0]      = a_reg.byp1;
    assign a_byp[1]      = a_reg.byp2;
    assign a_byp_data[0] = a_reg.byp_data1;
    assign a_byp_data[1] = a_reg.byp_data2;
    assign rd_data[0]    = bus.rfRdData1;
    assign rd_data[1]    = bus.rfRdData2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // A stalled entry re-reads its own registers; otherwise the new
            // issue's registers are read so data is ready when it lands in A.
            assign rd_addr[gi] = a_hold ? a_rs[gi] : in_rs[gi];
            // B compares against the entry entering it on advance, else the
            // entry it holds (B cannot be stalled while A advances).
            assign b_addr[gi]  = a_adv ? a_rs[gi] : b_rs_reg[gi];

            opf_hazard_match #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_a_match (
                .wb_enable (bus.wbEnable),
                .wb_addr   (bus.wbAddr),
                .wb_data   (bus.wbData),
                .addr      (rd_addr[gi]),
                .hit       (hit_a[gi]),
                .data      (data_a[gi])
            );

            opf_hazard_match #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_b_match (
                .wb_enable (bus.wbEnable),
                .wb_addr   (bus.wbAddr),
                .wb_data   (bus.wbData),
                .addr      (b_addr[gi]),
                .hit       (hit_b[gi]),
                .data      (data_b[gi])
            );

`ifdef OPF_ZERO_REG_EN
            assign a_op[gi] = (a_rs[gi] == ZERO_ADDR) ? '0
                            : (a_byp[gi] ? a_byp_data[gi] : rd_data[gi]);
`else
            assign a_op[gi] = a_byp[gi] ? a_byp_data[gi] : rd_data[gi];
`endif
            // A write on the advancing edge is newer than anything in A.
            assign b_op_next[gi] = hit_b[gi] ? data_b[gi] : a_op[gi];
        end
    endgenerate

    // Hold off issue for one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_done_reg <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
        end
    end

    // Stage A: capture new issues, track writes to a stalled entry's sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            a_reg       <= '0;
        end else if (accept) begin
            a_valid_reg     <= 1'b1;
            a_reg.rs1       <= bus.inRs1;
            a_reg.rs2       <= bus.inRs2;
            a_reg.tag       <= bus.inTag;
            a_reg.byp1      <= hit_a[0];
            a_reg.byp2      <= hit_a[1];
            a_reg.byp_data1 <= data_a[0];
            a_reg.byp_data2 <= data_a[1];
        end else if (a_adv) begin
            a_valid_reg <= 1'b0;
        end else if (a_valid_reg) begin
            if (hit_a[0]) begin
                a_reg.byp1      <= 1'b1;
                a_reg.byp_data1 <= data_a[0];
            end
            if (hit_a[1]) begin
                a_reg.byp2      <= 1'b1;
                a_reg.byp_data2 <= data_a[1];
            end
        end
    end

    // Stage B: output register, kept coherent with writes while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_tag_reg   <= '0;
            for (int i = 0; i < 2; i++) begin
                out_op_reg[i] <= '0;
                b_rs_reg[i]   <= '0;
            end
        end else if (a_adv) begin
            out_valid_reg <= 1'b1;
            out_tag_reg   <= a_reg.tag;
            for (int i = 0; i < 2; i++) begin
                out_op_reg[i] <= b_op_next[i];
                b_rs_reg[i]   <= a_rs[i];
            end
        end else if (bus.outReady) begin
            out_valid_reg <= 1'b0;
        end else if (out_valid_reg) begin
            for (int i = 0; i < 2; i++) begin
                if (hit_b[i]) begin
                    out_op_reg[i] <= data_b[i];
                end
            end
        end
    end

    assign bus.inReady   = in_ready;
    assign bus.rfRdAddr1 = rd_addr[0];
    assign bus.rfRdAddr2 = rd_addr[1];
    assign bus.outValid  = out_valid_reg;
    assign bus.outOp1    = out_op_reg[0];
    assign bus.outOp2    = out_op_reg[1];
    assign bus.outTag    = out_tag_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch. Models the registered register file,
// predicts every output from a scoreboard of issued instructions, and runs
// a table of handshake vectors plus directed hazard sequences.
// Honours OPF_ZERO_REG_EN when defined for the build.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int W = OPF_WORD_SIZE;
    localparam int A = OPF_ADDR_SIZE;
    localparam int T = OPF_TAG_SIZE;

`ifdef OPF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct {
        logic [A-1:0] rs1;
        logic [A-1:0] rs2;
        logic [T-1:0] tag;
    } sb_t;

    typedef struct {
        logic         iv;
        logic [A-1:0] rs1;
        logic [A-1:0] rs2;
        logic [T-1:0] tag;
        logic         ordy;
        logic         we;
        logic [A-1:0] wa;
        logic [W-1:0] wd;
        logic         exp_rdy;
        logic         exp_ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    sb_t  q[$];
    vec_t vecs[11];
    logic [W-1:0] mem [0:(1<<A)-1];
    logic [W-1:0] init_val [0:(1<<A)-1];
    logic [W-1:0] zexp;

    always #5 clk = ~clk;

    operand_fetch_if #(.WORD_SIZE(W), .ADDR_SIZE(A), .TAG_SIZE(T)) bus ();

    operand_fetch #(.WORD_SIZE(W), .ADDR_SIZE(A), .TAG_SIZE(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: registered reads return the contents before a same-edge write.
    always @(posedge clk) begin
        bus.rfRdData1 <= mem[bus.rfRdAddr1];
        bus.rfRdData2 <= mem[bus.rfRdAddr2];
        if (bus.wbEnable) mem[bus.wbAddr] <= bus.wbData;
    end

    function automatic logic [W-1:0] exp_op(input logic [A-1:0] rs);
        if (ZERO_EN && rs == '0) return '0;
        return mem[rs];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [A-1:0] r1, input logic [A-1:0] r2,
                         input logic [T-1:0] tg, input logic ordy, input logic we,
                         input logic [A-1:0] wa, input logic [W-1:0] wd);
        bus.inValid  = iv;
        bus.inRs1    = r1;
        bus.inRs2    = r2;
        bus.inTag    = tg;
        bus.outReady = ordy;
        bus.wbEnable = we;
        bus.wbAddr   = wa;
        bus.wbData   = wd;
    endtask

    // One clock: record accepts, score handshakes, advance to the next negedge.
    task automatic tick();
        sb_t e;
        #1;
        if (!rst && bus.inValid && bus.inReady)
            q.push_back('{bus.inRs1, bus.inRs2, bus.inTag});
        if (!rst && bus.outValid && bus.outReady) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: outValid=1 tag %0d, expected no output", bus.outTag);
            end else begin
                e = q.pop_front();
                $display("out tag=%0d rs1=%0d rs2=%0d op1=%h op2=%h",
                         bus.outTag, e.rs1, e.rs2, bus.outOp1, bus.outOp2);
                check("sb_op1", 32'(bus.outOp1), 32'(exp_op(e.rs1)));
                check("sb_op2", 32'(bus.outOp2), 32'(exp_op(e.rs2)));
                check("sb_tag", 32'(bus.outTag), 32'(e.tag));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 3'd2, 4'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 3'd3, 3'd4, 4'd1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd5, 3'd6, 4'd2, 1'b0, 1'b1, 3'd5, 16'h5A5A, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'd5, 3'd6, 4'd2, 1'b0, 1'b1, 3'd3, 16'h3C3C, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'd5, 3'd6, 4'd2, 1'b1, 1'b1, 3'd6, 16'h6E6E, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 3'd2, 3'd2, 4'd3, 1'b0, 1'b1, 3'd2, 16'h2B2B, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 3'd6, 16'h6F6F, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};

        init_val[0] = 16'h0F0F; init_val[1] = 16'h1111;
        init_val[2] = 16'h2222; init_val[3] = 16'h1234;
        init_val[4] = 16'h4444; init_val[5] = 16'h5555;
        init_val[6] = 16'h6666; init_val[7] = 16'h7070;

        // Reset with register preload through the write port.
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < (1 << A); i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, 1'b1, A'(i), init_val[i]);
            tick();
        end
        check("rst_in_ready", 32'(bus.inReady), 32'd0);
        check("rst_out_valid", 32'(bus.outValid), 32'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        #1;
        check("first_cycle_in_ready", 32'(bus.inReady), 32'd0);
        check("rst_out_op1", 32'(bus.outOp1), 32'd0);
        check("rst_out_op2", 32'(bus.outOp2), 32'd0);
        check("rst_out_tag", 32'(bus.outTag), 32'd0);
        tick();
        check("second_cycle_in_ready", 32'(bus.inReady), 32'd1);

        // Plain read of reg3 on both ports, two-cycle latency.
        drive(1'b1, 3'd3, 3'd3, 4'd5, 1'b1, 1'b0, '0, '0);
        tick();
        check("lat_not_yet_valid", 32'(bus.outValid), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        check("lat_valid", 32'(bus.outValid), 32'd1);
        check("reg3_op1", 32'(bus.outOp1), 32'h1234);
        check("reg3_op2", 32'(bus.outOp2), 32'h1234);
        check("reg3_tag", 32'(bus.outTag), 32'd5);
        tick();

        // Write on the issue edge must bypass the stale read.
        drive(1'b1, 3'd2, 3'd5, 4'd1, 1'b1, 1'b1, 3'd2, 16'hBEEF);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        check("issue_edge_bypass", 32'(bus.outOp1), 32'hBEEF);
        tick();

        // Handshake table with backpressure and hazards.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].tag,
                  vecs[i].ordy, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.inReady), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.outValid), 32'(vecs[i].exp_ov));
            tick();
        end

        // Stalled A entry sees two writes to reg1; newest wins.
        drive(1'b1, 3'd6, 3'd6, 4'd2, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b1, 3'd1, 3'd7, 4'd3, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd1, 16'h00AA);
        #1;
        check("stall_in_ready_a", 32'(bus.inReady), 32'd0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd1, 16'h00BB);
        #1;
        check("stall_in_ready_b", 32'(bus.inReady), 32'd0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        check("stall_in_ready_c", 32'(bus.inReady), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        check("stall_newest_write", 32'(bus.outOp1), 32'h00BB);
        tick();

        // Stalled B snoops a write to its op2 source.
        drive(1'b1, 3'd5, 3'd4, 4'd4, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        check("snoop_before_valid", 32'(bus.outValid), 32'd1);
        check("snoop_before_op2", 32'(bus.outOp2), 32'h4444);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd4, 16'h7777);
        tick();
        check("snoop_after_op2", 32'(bus.outOp2), 32'h7777);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        tick();

        // Eight back-to-back issues with a write every cycle.
        for (int k = 0; k < 11; k++) begin
            drive(k < 8, A'(k), A'(7 - k), T'(k), 1'b1, 1'b1, A'(k + 3), W'(16'hC000 + k));
            #1;
            if (k < 8) check("stream_in_ready", 32'(bus.inReady), 32'd1);
            if (k >= 2 && k <= 9) check("stream_out_valid", 32'(bus.outValid), 32'd1);
            if (k == 10) check("stream_drained", 32'(bus.outValid), 32'd0);
            tick();
        end

        // Reset mid-stream drops everything in flight.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, A'(k + 1), A'(k + 2), T'(8 + k), 1'b1, 1'b0, '0, '0);
            tick();
        end
        rst = 1'b1;
        q.delete();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        check("midrst_out_valid", 32'(bus.outValid), 32'd0);
        check("midrst_out_op1", 32'(bus.outOp1), 32'd0);
        check("midrst_out_op2", 32'(bus.outOp2), 32'd0);
        check("midrst_out_tag", 32'(bus.outTag), 32'd0);
        check("midrst_in_ready", 32'(bus.inReady), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_first_in_ready", 32'(bus.inReady), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        check("midrst_no_output", 32'(bus.outValid), 32'd0);

        // Register 0: general purpose by default, hardwired zero when enabled.
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 3'd0, 16'hFFFF);
        tick();
        drive(1'b1, 3'd0, 3'd3, 4'd9, 1'b1, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        zexp = ZERO_EN ? 16'h0000 : 16'hFFFF;
        check("reg0_op1", 32'(bus.outOp1), 32'(zexp));
        tick();
        drive(1'b1, 3'd0, 3'd0, 4'd10, 1'b1, 1'b1, 3'd0, 16'hABCD);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
        tick();
        zexp = ZERO_EN ? 16'h0000 : 16'hABCD;
        check("reg0_bypass_op1", 32'(bus.outOp1), 32'(zexp));
        check("reg0_bypass_op2", 32'(bus.outOp2), 32'(zexp));
        tick();
        tick();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipelined operand-fetch stage sitting directly downstream of the 2-read/1-write register file.
- Accepts issued instructions, drives the file's two read addresses and captures the registered read data one cycle later.
- Resolves read-during-write hazards against the file's write port and presents both operands to execute over a valid/ready handshake.
- Sustains one instruction per cycle.

Parameters:
- WORD_SIZE, 16, operand width; matches the register file.
- ADDR_SIZE, 3, register address width; the file holds 2**ADDR_SIZE registers.
- TAG_SIZE, 4, width of opaque per-instruction sideband carried alongside the operands.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- inValid  in  1  issue request
- inReady  out  1  stage can accept this cycle
- inRs1  in  ADDR_SIZE  source register 1
- inRs2  in  ADDR_SIZE  source register 2
- inTag  in  TAG_SIZE  sideband, passed through unchanged
- rfRdAddr1  out  ADDR_SIZE  to register file rdAddr1
- rfRdAddr2  out  ADDR_SIZE  to register file rdAddr2
- rfRdData1  in  WORD_SIZE  from register file rdData1 (registered, 1-cycle latency)
- rfRdData2  in  WORD_SIZE  from register file rdData2
- wbEnable  in  1  tap of the register file wrtEnable
- wbAddr  in  ADDR_SIZE  tap of wrtAddr
- wbData  in  WORD_SIZE  tap of wrtData
- outValid  out  1  operands valid
- outReady  in  1  downstream accepts
- outOp1  out  WORD_SIZE  operand 1
- outOp2  out  WORD_SIZE  operand 2
- outTag  out  TAG_SIZE  sideband

Behaviour:
- Two stages: A (address issued, waiting on rfRdData) and B (output register).
- Reset: aValid=0, outValid=0, outOp1/outOp2/outTag=0, all bypass flags=0.
- inReady is forced 0 while rst=1 and is 0 for the first cycle after reset.
- Register file reads are modelled as: read data reflects state *before* a same-edge write, with no internal forwarding.
- Handshakes:
  - accept = inValid && inReady.
  - aAdv = aValid && (!outValid || outReady).
  - inReady = !aValid || aAdv.
- Address mux: rfRdAddrN = (aValid && !aAdv) ? aRsN : inRsN. A stalled A entry re-reads its own registers every cycle.
- Bypass capture:
  - On accept: bypN <= wbEnable && wbAddr==inRsN; bypDataN <= wbData.
  - While A is held: any wbEnable && wbAddr==aRsN sets bypN and overwrites bypDataN. The newest write wins.
- A operand: opN = bypN ? bypDataN : rfRdDataN.
- On aAdv: outOpN <= opN with the same-cycle write check applied on top (wbEnable && wbAddr==aRsN selects wbData); outTag <= aTag; outValid <= 1.
- B snoop: while outValid && !outReady, a write matching the stored rsN updates outOpN with wbData.
- outValid clears on outReady && !aAdv.
- Latency: accept at edge T, outValid high after edge T+2. Back-to-back accepts give back-to-back outputs.
- Both operands naming the same register get identical values, including when bypassed.
- rst mid-operation drops all in-flight entries; no output is produced for them.

Optional Feature:
- OPF_ZERO_REG_EN defined:
  - Register 0 is hardwired zero: any operand with rs==0 yields 0, regardless of rfRdData or writes to address 0.
  - No bypass or snoop is applied for address 0.
- OPF_ZERO_REG_EN undefined: register 0 is general purpose, identical to all others.

Decomposition:
- Shared package: WORD_SIZE/ADDR_SIZE defaults, the operand-stage entry struct (rs1, rs2, tag, byp1, byp2, bypData1, bypData2), and the ZERO_ADDR constant.
- One natural sub-module, opf_hazard_match: per-operand compare of wbEnable/wbAddr against an address, returning hit and data. Instantiated twice for A and twice for B.

Test Plan:
- Reg3=0x1234; issue rs1=3, rs2=3, tag=5 with outReady=1 -> two cycles later outOp1=outOp2=0x1234, outTag=5.
- Write reg2=0xBEEF in the same cycle as issuing rs1=2 -> outOp1=0xBEEF, not the stale value.
- Hold outReady=0 with B full; write reg1=0x00AA, then reg1=0x00BB while the A entry reads reg1 -> on release, A delivers 0x00BB and inReady stays 0 throughout the stall.
- B holding op2 from reg4; write reg4=0x7777 while outReady=0 -> outOp2 becomes 0x7777 before the handshake.
- Stream 8 issues with outReady=1 -> 8 consecutive outValid cycles, in order, tags 0..7; then rst mid-stream -> outValid=0 the next cycle and outputs are 0.
- OPF_ZERO_REG_EN: write reg0=0xFFFF, then issue rs1=0 -> outOp1=0. Without the macro -> 0xFFFF.
